dmem_be: RTL and testbench

- Parametrised big-endian, byte-addressed data memory built on distributed RAM. Next generation of the word/byte scratch RAM.
- Adds byte/half/word loads and stores, sign or zero extension on loads, and misalignment detection.
- Adds a valid/ready request port with a registered one-cycle response, plus an optional post-reset clear sequencer.
- Sits between the core's memory stage and local data storage.

---
 rtl/dmem_be.sv | 149 ++++++++++++++
 tb/tb_dmem_be.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_be.sv
// Big-endian byte-addressed data memory: byte/half/word loads and stores over four byte-lane RAMs,
// valid/ready request port with a registered one-cycle response and an optional post-reset clear.
module dmem_be #(
  parameter int ADDR_W         = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int ROW_W = ADDR_W - 2;
  localparam int NROWS = DEPTH / 4;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] clrCnt_q, clrCnt_d;
  logic             respValid_q;
  logic [31:0]      respRdata_q, respRdata_d;
  logic             respErr_q, respErr_d;

  logic             accept;
  logic             clearing;
  logic             isErr;
  logic [ROW_W-1:0] row;
  logic [1:0]       off;
  logic [7:0]       rdLane [4];
  logic [7:0]       byteV;
  logic [15:0]      halfV;
  logic [31:0]      loadData;
  logic [3:0]       weLane;
  logic [3:0][7:0]  wrLane;
  logic [ROW_W-1:0] wrRow;

  assign row       = req_addr[ADDR_W-1:2];
  assign off       = req_addr[1:0];
  assign req_ready = (state_q == ST_READY) && !rst;
  assign clearing  = (state_q == ST_CLEAR) && !rst;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q == ST_CLEAR);

  // Lane 0 holds the byte at offset 0 of each word, i.e. the most significant byte.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem [NROWS];
    always_ff @(posedge clk) begin
      if (weLane[g]) mem[wrRow] <= wrLane[g];
    end
    assign rdLane[g] = mem[row];
  end

  always_comb begin
    isErr = (req_size == 2'b11) ||
            ((req_size == 2'b01) && off[0]) ||
            ((req_size == 2'b10) && (off != 2'b00));
  end

  always_comb begin
    byteV    = rdLane[off];
    halfV    = off[1] ? {rdLane[2], rdLane[3]} : {rdLane[0], rdLane[1]};
    loadData = {rdLane[0], rdLane[1], rdLane[2], rdLane[3]};
    case (req_size)
      2'b00:   loadData = req_signed ? {{24{byteV[7]}}, byteV} : {24'h0, byteV};
      2'b01:   loadData = req_signed ? {{16{halfV[15]}}, halfV} : {16'h0, halfV};
      default: ;
    endcase
  end

  // Clear sweeps zero across a whole row per cycle; otherwise only legal accepted stores write.
  always_comb begin
    weLane = '0;
    wrLane = '0;
    wrRow  = row;
    if (clearing) begin
      weLane = '1;
      wrRow  = clrCnt_q;
    end else if (accept && req_we && !isErr) begin
      case (req_size)
        2'b00: begin
          weLane[off] = 1'b1;
          wrLane[off] = req_wdata[7:0];
        end
        2'b01: begin
          weLane[{off[1], 1'b0}] = 1'b1;
          wrLane[{off[1], 1'b0}] = req_wdata[15:8];
          weLane[{off[1], 1'b1}] = 1'b1;
          wrLane[{off[1], 1'b1}] = req_wdata[7:0];
        end
        default: begin
          weLane = '1;
          wrLane = {req_wdata[7:0], req_wdata[15:8], req_wdata[23:16], req_wdata[31:24]};
        end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    case (state_q)
      ST_CLEAR: begin
        clrCnt_d = clrCnt_q + ROW_W'(1);
        if (clrCnt_q == '1) state_d = ST_READY;
      end
      default: ;
    endcase
  end

  always_comb begin
    respRdata_d = respRdata_q;
    respErr_d   = respErr_q;
    if (accept) begin
      respErr_d   = isErr;
      respRdata_d = (isErr || req_we) ? 32'h0 : loadData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clrCnt_q    <= '0;
      respValid_q <= 1'b0;
      respRdata_q <= 32'h0;
      respErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clrCnt_q    <= clrCnt_d;
      respValid_q <= accept;
      respRdata_q <= respRdata_d;
      respErr_q   <= respErr_d;
    end
  end

  assign resp_valid = respValid_q;
  assign resp_rdata = respRdata_q;
  assign resp_err   = respErr_q;

endmodule

// File: tb/tb_dmem_be.sv
// Directed bench for dmem_be: clear timing, big-endian loads/stores, error responses,
// back-to-back traffic and reset during the clear sequence.
module tb_dmem_be;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;

   int nChecks = 0;
   int nErrs   = 0;

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [31:0] expData;
      logic        expErr;
   } vec_t;

   vec_t vecs[$];

   dmem_be #(.ADDR_W(10), .CLEAR_ON_RESET(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_signed(req_signed),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err),
      .busy      (busy)
   );

   // Free-running 10 ns clock; inputs change and outputs are sampled on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A hung design must still end with a visible failure.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(string n, logic we, logic [1:0] sz, logic sg,
                               logic [9:0] a, logic [31:0] wd, logic [31:0] ed, logic ee);
      vec_t v;
      v.name = n; v.we = we; v.size = sz; v.sgn = sg;
      v.addr = a; v.wdata = wd; v.expData = ed; v.expErr = ee;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrs++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      req_valid  = 1'b1;
      req_we     = v.we;
      req_size   = v.size;
      req_signed = v.sgn;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
   endtask

   // Counts falling edges with busy high; any ready or response during clear is a violation.
   task automatic waitClear(output int busyCycles, output int badCycles);
      busyCycles = 0;
      badCycles  = 0;
      while (busy && busyCycles < 400) begin
         if (req_ready || resp_valid) badCycles++;
         busyCycles++;
         @(negedge clk);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " req_ready"},  {31'h0, req_ready},  32'h0);
      checkOutput({tag, " resp_valid"}, {31'h0, resp_valid}, 32'h0);
      checkOutput({tag, " resp_rdata"}, resp_rdata,          32'h0);
      checkOutput({tag, " resp_err"},   {31'h0, resp_err},   32'h0);
      checkOutput({tag, " busy"},       {31'h0, busy},       32'h1);
   endtask

   initial begin
      int busyCycles;
      int badCycles;

      vecs.push_back(mk("st_w_020",    1, 2'b10, 0, 10'h020, 32'h11223344, 32'h00000000, 0));
      vecs.push_back(mk("ld_bu_020",   0, 2'b00, 0, 10'h020, 32'h0,        32'h00000011, 0));
      vecs.push_back(mk("ld_bu_021",   0, 2'b00, 0, 10'h021, 32'h0,        32'h00000022, 0));
      vecs.push_back(mk("ld_bu_022",   0, 2'b00, 0, 10'h022, 32'h0,        32'h00000033, 0));
      vecs.push_back(mk("ld_bu_023",   0, 2'b00, 0, 10'h023, 32'h0,        32'h00000044, 0));
      vecs.push_back(mk("ld_hu_022",   0, 2'b01, 0, 10'h022, 32'h0,        32'h00003344, 0));
      vecs.push_back(mk("st_b_031",    1, 2'b00, 0, 10'h031, 32'hFFFFFF80, 32'h00000000, 0));
      vecs.push_back(mk("ld_bs_031",   0, 2'b00, 1, 10'h031, 32'h0,        32'hFFFFFF80, 0));
      vecs.push_back(mk("ld_bu_031",   0, 2'b00, 0, 10'h031, 32'h0,        32'h00000080, 0));
      vecs.push_back(mk("st_h_040",    1, 2'b01, 0, 10'h040, 32'h1234BEEF, 32'h00000000, 0));
      vecs.push_back(mk("ld_hs_040",   0, 2'b01, 1, 10'h040, 32'h0,        32'hFFFFBEEF, 0));
      vecs.push_back(mk("ld_hu_040",   0, 2'b01, 0, 10'h040, 32'h0,        32'h0000BEEF, 0));
      vecs.push_back(mk("st_w_044",    1, 2'b10, 0, 10'h044, 32'hCAFEF00D, 32'h00000000, 0));
      vecs.push_back(mk("err_st_w_045",1, 2'b10, 0, 10'h045, 32'h12345678, 32'h00000000, 1));
      vecs.push_back(mk("err_ld_h_041",0, 2'b01, 1, 10'h041, 32'h0,        32'h00000000, 1));
      vecs.push_back(mk("err_ld_sz3",  0, 2'b11, 0, 10'h044, 32'h0,        32'h00000000, 1));
      vecs.push_back(mk("err_st_sz3",  1, 2'b11, 0, 10'h044, 32'hFFFFFFFF, 32'h00000000, 1));
      vecs.push_back(mk("err_st_h_047",1, 2'b01, 0, 10'h047, 32'h00005555, 32'h00000000, 1));
      vecs.push_back(mk("ld_w_044",    0, 2'b10, 0, 10'h044, 32'h0,        32'hCAFEF00D, 0));
      vecs.push_back(mk("ld_w_040",    0, 2'b10, 0, 10'h040, 32'h0,        32'hBEEF0000, 0));
      vecs.push_back(mk("ld_w_030",    0, 2'b10, 0, 10'h030, 32'h0,        32'h00800000, 0));
      vecs.push_back(mk("st_w_100",    1, 2'b10, 0, 10'h100, 32'hA5A5A5A5, 32'h00000000, 0));
      vecs.push_back(mk("ld_w_100",    0, 2'b10, 0, 10'h100, 32'h0,        32'hA5A5A5A5, 0));
      vecs.push_back(mk("st_b_103",    1, 2'b00, 0, 10'h103, 32'h0000007F, 32'h00000000, 0));
      vecs.push_back(mk("ld_bs_103",   0, 2'b00, 1, 10'h103, 32'h0,        32'h0000007F, 0));
      vecs.push_back(mk("ld_w_100b",   0, 2'b10, 0, 10'h100, 32'h0,        32'hA5A5A57F, 0));
      vecs.push_back(mk("ld_hs_102",   0, 2'b01, 1, 10'h102, 32'h0,        32'hFFFFA57F, 0));

      // Power-up: reset held with a word load at 0x010 already waiting.
      rst = 1'b1;
      applyStimulus(mk("hold_ld_010", 0, 2'b10, 0, 10'h010, 32'h0, 32'h0, 0));
      repeat (2) @(negedge clk);
      checkResetOutputs("por");
      rst = 1'b0;

      waitClear(busyCycles, badCycles);
      checkOutput("clear_len", 32'(busyCycles), 32'd256);
      checkOutput("clear_quiet", 32'(badCycles), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("first_valid", {31'h0, resp_valid}, 32'h1);
      checkOutput("first_rdata", resp_rdata, 32'h0);
      checkOutput("first_err",   {31'h0, resp_err}, 32'h0);
      @(negedge clk);
      checkOutput("idle_valid",  {31'h0, resp_valid}, 32'h0);
      checkOutput("ready_on",    {31'h0, req_ready},  32'h1);

      // Continuous back-to-back stream: one request per cycle, response checked the next cycle.
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput({vecs[i].name, " valid"}, {31'h0, resp_valid}, 32'h1);
         checkOutput({vecs[i].name, " rdata"}, resp_rdata, vecs[i].expData);
         checkOutput({vecs[i].name, " err"},   {31'h0, resp_err}, {31'h0, vecs[i].expErr});
      end
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("tail_valid", {31'h0, resp_valid}, 32'h0);
      checkOutput("tail_hold",  resp_rdata, 32'hFFFFA57F);

      // Reset in READY, then again 100 cycles into the clear; the clear must restart from zero.
      rst = 1'b1;
      #1;
      checkResetOutputs("rst1");
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(mk("hold_ld_100", 0, 2'b10, 0, 10'h100, 32'h0, 32'h0, 0));
      badCycles = 0;
      repeat (100) begin
         if (req_ready || resp_valid || !busy) badCycles++;
         @(negedge clk);
      end
      checkOutput("midclear_quiet", 32'(badCycles), 32'd0);
      rst = 1'b1;
      #1;
      checkResetOutputs("rst2");
      @(negedge clk);
      rst = 1'b0;
      waitClear(busyCycles, badCycles);
      checkOutput("reclear_len",   32'(busyCycles), 32'd256);
      checkOutput("reclear_quiet", 32'(badCycles), 32'd0);
      @(negedge clk);
      checkOutput("cleared_100 valid", {31'h0, resp_valid}, 32'h1);
      checkOutput("cleared_100 rdata", resp_rdata, 32'h0);
      applyStimulus(mk("ld_w_044c", 0, 2'b10, 0, 10'h044, 32'h0, 32'h0, 0));
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("cleared_044 rdata", resp_rdata, 32'h0);
      checkOutput("cleared_044 err",   {31'h0, resp_err}, 32'h0);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrs);
      $finish;
   end

endmodule
